// File: rtl/kugelblitz_rewrite_if.sv
// AXI-stream bundle used on both sides of the kugelblitz byte rewrite stage.
// The source drives the payload and tvalid; the sink drives tready.
interface kugelblitz_rewrite_if #(
   parameter int DATA_WIDTH = 512,
   parameter int USER_WIDTH = 1
);
   localparam int KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [USER_WIDTH-1:0] tuser;

   modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/kugelblitz_rewrite.sv
// Packet-aware multi-rule byte rewrite on one AXI-stream path, one register stage.
// Rules are staged in a pending table and snapshotted into the active table on each first beat.
module kugelblitz_rewrite #(
   parameter int DATA_WIDTH     = 512,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int USER_WIDTH     = 1,
   parameter int N_RULES        = 4,
   parameter int OFFSET_WIDTH   = 14,
   parameter int RULE_IDX_WIDTH = (N_RULES > 1) ? $clog2(N_RULES) : 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   kugelblitz_rewrite_if.slave       s_axis,
   kugelblitz_rewrite_if.master      m_axis,
   input  logic                      cfg_wr_en,
   input  logic [RULE_IDX_WIDTH-1:0] cfg_wr_idx,
   input  logic                      cfg_enable,
   input  logic [OFFSET_WIDTH-1:0]   cfg_offset,
   input  logic [7:0]                cfg_data,
   input  logic [7:0]                cfg_mask,
   output logic [31:0]               stat_rewrite_count
);
   localparam int LANE_WIDTH = $clog2(KEEP_WIDTH);
   localparam int BEAT_WIDTH = OFFSET_WIDTH - LANE_WIDTH;
   localparam int HIT_WIDTH  = $clog2(KEEP_WIDTH + 1);

   typedef struct packed {
      logic                    en;
      logic [OFFSET_WIDTH-1:0] offset;
      logic [7:0]              data;
      logic [7:0]              mask;
   } rule_t;

   rule_t                 pending_q [N_RULES];
   rule_t                 active_q  [N_RULES];
   logic [BEAT_WIDTH-1:0] beat_q, beat_d;
   logic                  in_packet_q, in_packet_d;
   logic                  tvalid_q, tvalid_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic [KEEP_WIDTH-1:0] tkeep_q;
   logic                  tlast_q;
   logic [USER_WIDTH-1:0] tuser_q;
   logic [31:0]           stat_q, stat_d;
   logic [32:0]           stat_sum;
   logic [HIT_WIDTH-1:0]  hits;

   logic                    accept;
   logic                    first_beat;
   logic                    beat_sat;
   rule_t                   cand;
   rule_t                   rule_sel;
   logic                    hit;
   logic [OFFSET_WIDTH-1:0] lane_off;
   logic [7:0]              byte_in;

   assign s_axis.tready = !tvalid_q || m_axis.tready;
   assign accept        = s_axis.tvalid && s_axis.tready;
   assign first_beat    = !in_packet_q;
   assign beat_sat      = &beat_q;

   // Lane rewrite: the last matching rule in index order wins; a saturated beat index matches nothing.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      tdata_d  = '0;
      hits     = '0;
      cand     = '0;
      rule_sel = '0;
      hit      = 1'b0;
      lane_off = '0;
      byte_in  = '0;
      for (int k = 0; k < KEEP_WIDTH; k++) begin
         lane_off = {beat_q, LANE_WIDTH'(k)};
         byte_in  = s_axis.tdata[8*k +: 8];
         hit      = 1'b0;
         rule_sel = '0;
         for (int r = 0; r < N_RULES; r++) begin
            cand = first_beat ? pending_q[r] : active_q[r];
            if (cand.en && (cand.offset == lane_off) && !beat_sat) begin
               hit      = 1'b1;
               rule_sel = cand;
            end
         end
         if (!s_axis.tkeep[k]) begin
            tdata_d[8*k +: 8] = 8'h00;
         end else if (hit) begin
            tdata_d[8*k +: 8] = (byte_in & ~rule_sel.mask) | (rule_sel.data & rule_sel.mask);
            hits              = hits + HIT_WIDTH'(1);
         end else begin
            tdata_d[8*k +: 8] = byte_in;
         end
      end
   end

   always_comb begin
      beat_d      = beat_q;
      in_packet_d = in_packet_q;
      tvalid_d    = tvalid_q;
      stat_sum    = {1'b0, stat_q} + 33'(hits);
      stat_d      = stat_q;
      if (accept) begin
         tvalid_d = 1'b1;
         stat_d   = stat_sum[32] ? '1 : stat_sum[31:0];
         if (s_axis.tlast) begin
            beat_d      = '0;
            in_packet_d = 1'b0;
         end else begin
            in_packet_d = 1'b1;
            if (!beat_sat) beat_d = beat_q + BEAT_WIDTH'(1);
         end
      end else if (m_axis.tready) begin
         tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tvalid_q    <= 1'b0;
         tdata_q     <= '0;
         tkeep_q     <= '0;
         tlast_q     <= 1'b0;
         tuser_q     <= '0;
         beat_q      <= '0;
         in_packet_q <= 1'b0;
         stat_q      <= '0;
         // NOTE: both rule tables are small flop arrays with defined reset contents, so they are cleared here.
         for (int r = 0; r < N_RULES; r++) begin
            pending_q[r] <= '0;
            active_q[r]  <= '0;
         end
      end else begin
         tvalid_q    <= tvalid_d;
         beat_q      <= beat_d;
         in_packet_q <= in_packet_d;
         stat_q      <= stat_d;
         if (accept) begin
            tdata_q <= tdata_d;
            tkeep_q <= s_axis.tkeep;
            tlast_q <= s_axis.tlast;
            tuser_q <= s_axis.tuser;
         end
         // Snapshot sees the pending table before any same-cycle config write.
         if (accept && first_beat) active_q <= pending_q;
         if (cfg_wr_en && (32'(cfg_wr_idx) < N_RULES))
            pending_q[cfg_wr_idx] <= {cfg_enable, cfg_offset, cfg_data, cfg_mask};
      end
   end

   assign m_axis.tvalid      = tvalid_q;
   assign m_axis.tdata       = tdata_q;
   assign m_axis.tkeep       = tkeep_q;
   assign m_axis.tlast       = tlast_q;
   assign m_axis.tuser       = tuser_q;
   assign stat_rewrite_count = stat_q;
endmodule

// File: tb/tb_kugelblitz_rewrite.sv
// Self-checking bench for kugelblitz_rewrite: directed scenarios plus randomized packets,
// checked against a byte-offset reference model of the rewrite rules.
`timescale 1ns/1ps
module tb_kugelblitz_rewrite;
   localparam int DW = 512;
   localparam int KW = DW / 8;
   localparam int NR = 4;
   localparam int OW = 14;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [0:0]    user;
   } beat_t;

   typedef struct {
      bit         en;
      int         off;
      logic [7:0] data;
      logic [7:0] mask;
   } mrule_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_wr_en;
   logic [1:0]  cfg_wr_idx;
   logic        cfg_enable;
   logic [OW-1:0] cfg_offset;
   logic [7:0]  cfg_data;
   logic [7:0]  cfg_mask;
   logic [31:0] stat;

   always #5 clk = ~clk;

   kugelblitz_rewrite_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) s_if ();
   kugelblitz_rewrite_if #(.DATA_WIDTH(DW), .USER_WIDTH(1)) m_if ();

   kugelblitz_rewrite #(
      .DATA_WIDTH(DW), .USER_WIDTH(1), .N_RULES(NR), .OFFSET_WIDTH(OW)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .s_axis             (s_if),
      .m_axis             (m_if),
      .cfg_wr_en          (cfg_wr_en),
      .cfg_wr_idx         (cfg_wr_idx),
      .cfg_enable         (cfg_enable),
      .cfg_offset         (cfg_offset),
      .cfg_data           (cfg_data),
      .cfg_mask           (cfg_mask),
      .stat_rewrite_count (stat)
   );

   int     total = 0;
   int     bad = 0;
   beat_t  pkt[$];
   beat_t  exp_q[$];
   beat_t  obs_q[$];
   mrule_t pend_m [NR];
   mrule_t snap_m [NR];
   longint exp_stat = 0;
   int     rdy_mode = 3;
   bit     mon_en = 1'b0;
   int     hs_err = 0;
   int     stable_err = 0;
   int     stall_cnt = 0;
   bit     hold_v = 1'b0;
   beat_t  hold_b;

   // Output monitor: records every transfer and watches handshake/hold rules when enabled.
   always @(negedge clk) begin
      beat_t cur;
      cur = {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser};
      if (!rst_n) begin
         hold_v = 1'b0;
      end else begin
         if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) obs_q.push_back(cur);
         if (mon_en) begin
            if (s_if.tready !== (!m_if.tvalid || m_if.tready)) hs_err++;
            if (hold_v && (m_if.tvalid !== 1'b1 || cur !== hold_b)) stable_err++;
            if (m_if.tvalid === 1'b1 && m_if.tready === 1'b0) stall_cnt++;
         end
         hold_v = (m_if.tvalid === 1'b1) && (m_if.tready === 1'b0);
         hold_b = cur;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: m_if.tready = 1'b1;
         1: m_if.tready = ~m_if.tready;
         2: m_if.tready = 1'($urandom_range(1));
         default: ;
      endcase
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom();
      return d;
   endfunction

   function automatic mrule_t mk_rule(bit en, int off, logic [7:0] data, logic [7:0] mask);
      mrule_t r;
      r.en = en; r.off = off; r.data = data; r.mask = mask;
      return r;
   endfunction

   // Reference model: byte at packet offset b*KW+k takes the highest-index enabled rule at that offset.
   task automatic model_beat(input beat_t in, input int b, output beat_t out);
      out = in;
      for (int k = 0; k < KW; k++) begin
         int         hit;
         logic [7:0] byt;
         byt = in.data[8*k +: 8];
         hit = -1;
         if (b < 255)
            for (int r = 0; r < NR; r++)
               if (snap_m[r].en && snap_m[r].off == b * KW + k) hit = r;
         if (!in.keep[k]) begin
            out.data[8*k +: 8] = 8'h00;
         end else if (hit >= 0) begin
            out.data[8*k +: 8] = (byt & ~snap_m[hit].mask) | (snap_m[hit].data & snap_m[hit].mask);
            exp_stat++;
         end
      end
      if (exp_stat > 64'hFFFF_FFFF) exp_stat = 64'hFFFF_FFFF;
   endtask

   task automatic model_clear();
      for (int r = 0; r < NR; r++) pend_m[r] = mk_rule(0, 0, 8'h00, 8'h00);
      exp_stat = 0;
   endtask

   task automatic cfg_write(input int idx, input mrule_t r);
      cfg_wr_en  = 1'b1;
      cfg_wr_idx = 2'(idx);
      cfg_enable = r.en;
      cfg_offset = OW'(r.off);
      cfg_data   = r.data;
      cfg_mask   = r.mask;
      pend_m[idx] = r;
      tick();
      cfg_wr_en = 1'b0;
   endtask

   // Drives the beats in pkt; optionally issues a config write in the cycle beat 0 is first presented.
   task automatic drive_pkt(input bit do_wr, input int wr_idx, input mrule_t wr_r, input int gap_pct);
      beat_t eb;
      bit    acc;
      int    guard;
      for (int b = 0; b < pkt.size(); b++) begin
         while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            s_if.tvalid = 1'b0;
            tick();
         end
         s_if.tvalid = 1'b1;
         s_if.tdata  = pkt[b].data;
         s_if.tkeep  = pkt[b].keep;
         s_if.tlast  = pkt[b].last;
         s_if.tuser  = pkt[b].user;
         if (do_wr && b == 0) begin
            cfg_wr_en  = 1'b1;
            cfg_wr_idx = 2'(wr_idx);
            cfg_enable = wr_r.en;
            cfg_offset = OW'(wr_r.off);
            cfg_data   = wr_r.data;
            cfg_mask   = wr_r.mask;
         end
         acc = 1'b0;
         guard = 0;
         while (!acc && guard < 200) begin
            @(negedge clk);
            acc = (s_if.tready === 1'b1);
            if (acc && b == 0) snap_m = pend_m;
            if (cfg_wr_en) pend_m[wr_idx] = wr_r;
            if (acc) begin
               model_beat(pkt[b], b, eb);
               exp_q.push_back(eb);
            end
            tick();
            cfg_wr_en = 1'b0;
            guard++;
         end
         if (!acc) begin
            total++; bad++;
            $display("FAIL drive_timeout beat=%0d accepted=0 required=1", b);
         end
      end
      s_if.tvalid = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      int n;
      n = 0;
      while (obs_q.size() < exp_q.size() && n < 400) begin
         tick();
         n++;
      end
      ok = (obs_q.size() == exp_q.size());
   endtask

   task automatic make_pkt(input int nbeats);
      beat_t b;
      pkt.delete();
      for (int i = 0; i < nbeats; i++) begin
         b.data = rand_data();
         b.keep = '1;
         b.last = (i == nbeats - 1);
         b.user = 1'($urandom_range(1));
         pkt.push_back(b);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rdy_mode = 3;
      m_if.tready = 1'b0;
      s_if.tvalid = 1'b1;
      s_if.tdata = rand_data();
      s_if.tkeep = '1;
      s_if.tlast = 1'b0;
      s_if.tuser = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         total++;
         if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid cycle=%0d got=%b want=0", c, m_if.tvalid); end
         total++;
         if (stat !== 32'd0) begin bad++; $display("FAIL reset_stat cycle=%0d got=%0d want=0", c, stat); end
         total++;
         if (s_if.tready !== 1'b1) begin bad++; $display("FAIL reset_tready cycle=%0d got=%b want=1", c, s_if.tready); end
      end
      total++;
      if (m_if.tdata !== '0 || m_if.tkeep !== '0 || m_if.tlast !== 1'b0 || m_if.tuser !== 1'b0) begin
         bad++;
         $display("FAIL reset_payload got keep=%h last=%b user=%b want all zero", m_if.tkeep, m_if.tlast, m_if.tuser);
      end
      s_if.tvalid = 1'b0;
      rst_n = 1'b1;
      m_if.tready = 1'b1;
      rdy_mode = 0;
      model_clear();
      tick();
   endtask

   task automatic test_single_rule();
      beat_t eb, ob;
      bit    ok;
      cfg_write(0, mk_rule(1, 5, 8'hAB, 8'hFF));
      make_pkt(1);
      pkt[0].data[8*5 +: 8] = 8'h12;
      drive_pkt(0, 0, mk_rule(0, 0, 8'h00, 8'h00), 0);
      total++;
      if (m_if.tvalid !== 1'b1 || m_if.tdata[8*5 +: 8] !== 8'hAB) begin
         bad++;
         $display("FAIL single_latency got valid=%b byte5=%h want valid=1 byte5=ab", m_if.tvalid, m_if.tdata[8*5 +: 8]);
      end
      wait_drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL single_drain got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL single_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
      total++;
      if (stat !== 32'd1) begin bad++; $display("FAIL single_stat got=%0d want=1", stat); end
   endtask

   task automatic test_cross_beat();
      beat_t eb, ob;
      bit    ok;
      cfg_write(0, mk_rule(0, 0, 8'h00, 8'h00));
      cfg_write(1, mk_rule(1, 70, 8'hF0, 8'hF0));
      make_pkt(3);
      pkt[1].data[8*6 +: 8] = 8'h3C;
      drive_pkt(0, 0, mk_rule(0, 0, 8'h00, 8'h00), 0);
      wait_drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL cross_drain got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      if (obs_q.size() == 3) begin
         total++;
         if (obs_q[1].data[8*6 +: 8] !== 8'hFC) begin bad++; $display("FAIL cross_lane6 got=%h want=fc", obs_q[1].data[8*6 +: 8]); end
         total++;
         if (obs_q[0].data !== pkt[0].data || obs_q[2].data !== pkt[2].data) begin
            bad++; $display("FAIL cross_untouched got beat0=%h want=%h", obs_q[0].data, pkt[0].data);
         end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL cross_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
      total++;
      if (stat !== exp_stat[31:0]) begin bad++; $display("FAIL cross_stat got=%0d want=%0d", stat, exp_stat); end
   endtask

   task automatic test_overlap_keep();
      beat_t eb, ob;
      bit    ok;
      cfg_write(1, mk_rule(0, 0, 8'h00, 8'h00));
      cfg_write(0, mk_rule(1, 2, 8'h11, 8'hFF));
      cfg_write(3, mk_rule(1, 2, 8'h55, 8'hFF));
      cfg_write(2, mk_rule(1, 130, 8'h77, 8'hFF));
      make_pkt(3);
      pkt[2].keep = 64'h000F;
      drive_pkt(0, 0, mk_rule(0, 0, 8'h00, 8'h00), 0);
      wait_drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL overlap_drain got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      if (obs_q.size() == 3) begin
         total++;
         if (obs_q[0].data[8*2 +: 8] !== 8'h55) begin bad++; $display("FAIL overlap_prio got=%h want=55", obs_q[0].data[8*2 +: 8]); end
         total++;
         if (obs_q[2].data[8*2 +: 8] !== 8'h77) begin bad++; $display("FAIL overlap_lastbeat got=%h want=77", obs_q[2].data[8*2 +: 8]); end
         total++;
         if (obs_q[2].data[DW-1:32] !== '0) begin bad++; $display("FAIL overlap_keepzero got=%h want=0", obs_q[2].data[DW-1:32]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL overlap_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
      total++;
      if (stat !== exp_stat[31:0]) begin bad++; $display("FAIL overlap_stat got=%0d want=%0d", stat, exp_stat); end
   endtask

   task automatic test_mid_cfg();
      beat_t eb, ob;
      bit    ok;
      for (int r = 0; r < NR; r++) cfg_write(r, mk_rule(0, 0, 8'h00, 8'h00));
      make_pkt(2);
      pkt[1].data[7:0] = 8'h00;
      drive_pkt(1, 0, mk_rule(1, 64, 8'hA5, 8'hFF), 0);
      drive_pkt(0, 0, mk_rule(0, 0, 8'h00, 8'h00), 0);
      wait_drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL midcfg_drain got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      if (obs_q.size() == 4) begin
         total++;
         if (obs_q[1].data[7:0] !== 8'h00) begin bad++; $display("FAIL midcfg_first got=%h want=00", obs_q[1].data[7:0]); end
         total++;
         if (obs_q[3].data[7:0] !== 8'hA5) begin bad++; $display("FAIL midcfg_second got=%h want=a5", obs_q[3].data[7:0]); end
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL midcfg_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_back_to_back_backpressure();
      beat_t eb, ob;
      bit    ok;
      hs_err = 0; stable_err = 0; stall_cnt = 0;
      mon_en = 1'b1;
      m_if.tready = 1'b1;
      rdy_mode = 1;
      make_pkt(4);
      drive_pkt(0, 0, mk_rule(0, 0, 8'h00, 8'h00), 0);
      wait_drain(ok);
      mon_en = 1'b0;
      rdy_mode = 0;
      m_if.tready = 1'b1;
      total++;
      if (!ok) begin bad++; $display("FAIL bp_count got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      total++;
      if (hs_err !== 0) begin bad++; $display("FAIL bp_tready got=%0d errors want=0", hs_err); end
      total++;
      if (stable_err !== 0) begin bad++; $display("FAIL bp_stable got=%0d errors want=0", stable_err); end
      total++;
      if (stall_cnt === 0) begin bad++; $display("FAIL bp_stalled got=0 stall cycles want>0"); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL bp_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_random();
      beat_t eb, ob;
      bit    ok;
      hs_err = 0; stable_err = 0;
      mon_en = 1'b1;
      rdy_mode = 2;
      for (int p = 0; p < 10; p++) begin
         for (int w = 0; w < int'($urandom_range(2)); w++)
            cfg_write(int'($urandom_range(NR - 1)),
                      mk_rule(1'($urandom_range(3) != 0), int'($urandom_range(5 * KW - 1)),
                              8'($urandom()), 8'($urandom())));
         make_pkt(int'($urandom_range(1, 5)));
         pkt[pkt.size() - 1].keep = {$urandom(), $urandom()};
         drive_pkt(1'($urandom_range(2) == 0), int'($urandom_range(NR - 1)),
                   mk_rule(1, int'($urandom_range(5 * KW - 1)), 8'($urandom()), 8'($urandom())), 30);
      end
      wait_drain(ok);
      mon_en = 1'b0;
      rdy_mode = 0;
      m_if.tready = 1'b1;
      total++;
      if (!ok) begin bad++; $display("FAIL rand_drain got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      total++;
      if (hs_err !== 0 || stable_err !== 0) begin bad++; $display("FAIL rand_handshake got=%0d/%0d errors want=0/0", hs_err, stable_err); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL rand_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
      total++;
      if (stat !== exp_stat[31:0]) begin bad++; $display("FAIL rand_stat got=%0d want=%0d", stat, exp_stat); end
   endtask

   task automatic test_reset_mid_packet();
      beat_t eb, ob;
      bit    ok;
      s_if.tvalid = 1'b1;
      s_if.tdata  = rand_data();
      s_if.tkeep  = '1;
      s_if.tlast  = 1'b0;
      s_if.tuser  = 1'b0;
      tick();
      s_if.tvalid = 1'b0;
      rst_n = 1'b0;
      tick();
      total++;
      if (m_if.tvalid !== 1'b0) begin bad++; $display("FAIL rstmid_tvalid got=%b want=0", m_if.tvalid); end
      rst_n = 1'b1;
      model_clear();
      obs_q.delete(); exp_q.delete();
      total++;
      if (stat !== 32'd0) begin bad++; $display("FAIL rstmid_stat got=%0d want=0", stat); end
      cfg_write(0, mk_rule(1, 5, 8'hC3, 8'hFF));
      make_pkt(1);
      drive_pkt(0, 0, mk_rule(0, 0, 8'h00, 8'h00), 0);
      wait_drain(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rstmid_drain got=%0d beats want=%0d", obs_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         eb = exp_q.pop_front(); ob = obs_q.pop_front(); total++;
         if (ob !== eb) begin
            bad++;
            $display("FAIL rstmid_beat got data=%h keep=%h last=%b want data=%h keep=%h last=%b", ob.data, ob.keep, ob.last, eb.data, eb.keep, eb.last);
         end
      end
      exp_q.delete(); obs_q.delete();
      total++;
      if (stat !== 32'd1) begin bad++; $display("FAIL rstmid_firstbeat_stat got=%0d want=1", stat); end
   endtask

   initial begin
      cfg_wr_en = 1'b0; cfg_wr_idx = '0; cfg_enable = 1'b0;
      cfg_offset = '0; cfg_data = '0; cfg_mask = '0;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
      m_if.tready = 1'b0;
      model_clear();
      test_reset();
      test_single_rule();
      test_cross_beat();
      test_overlap_keep();
      test_mid_cfg();
      test_back_to_back_backpressure();
      test_random();
      test_reset_mid_packet();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/kugelblitz_rewrite.md
Name: kugelblitz_rewrite

Overview:
- Multi-rule, packet-aware byte rewrite stage on one 512-bit AXI-stream path, with full tready backpressure.
- Each rule patches one byte at an absolute byte offset within a packet (any beat) under a bit mask.
- Rules are written through a simple config port and take effect only at packet boundaries.
- One instance per qsfp tx/rx direction, between the MAC-side FIFO and the datapath.

Parameters:
- DATA_WIDTH, 512, stream data width in bits; must be a multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width.
- N_RULES, 4, number of rewrite rules (1..16).
- OFFSET_WIDTH, 14, byte-offset width; max offset 16383.
- RULE_IDX_WIDTH, $clog2(N_RULES) (min 1), rule index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of packet
- s_axis_tuser  in  USER_WIDTH  input user
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  output end of packet
- m_axis_tuser  out  USER_WIDTH  output user
- cfg_wr_en  in  1  write one rule this cycle
- cfg_wr_idx  in  RULE_IDX_WIDTH  rule index to write
- cfg_enable  in  1  rule enable
- cfg_offset  in  OFFSET_WIDTH  byte offset from start of packet
- cfg_data  in  8  replacement byte
- cfg_mask  in  8  bits to replace (1 = replace)
- stat_rewrite_count  out  32  count of bytes actually rewritten

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Reset values, applied when rst_n=0 at a clk edge:
  - m_axis_tvalid=0; m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser = 0.
  - Beat counter = 0, in_packet = 0, stat_rewrite_count = 0.
  - All pending and active rules: enable=0, offset=0, data=0, mask=0.
- Reset mid-packet drops the output beat and the packet state. The next accepted beat is treated as a first beat.
- Pipeline and handshake:
  - One register stage, latency 1 cycle.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready (combinational).
  - A beat is accepted when s_axis_tvalid && s_axis_tready.
  - On accept, the output register loads the processed beat and m_axis_tvalid=1.
  - If m_axis_tready && !accept, m_axis_tvalid=0.
  - The output holds stable while m_axis_tvalid && !m_axis_tready.
- Position tracking:
  - Beat counter width is OFFSET_WIDTH - log2(KEEP_WIDTH).
  - The counter increments on each accepted beat and saturates at all-ones (no wrap).
  - The counter clears to 0 on an accepted beat with tlast.
  - Byte lane k of beat b has packet offset b*KEEP_WIDTH + k.
- Config:
  - A cfg_wr_en write updates pending rule [cfg_wr_idx] at the clock edge.
  - If cfg_wr_idx >= N_RULES, the write is ignored.
- Rule latching:
  - The active set is copied from pending when the first beat of a packet is accepted.
  - The first beat is processed with the pending set as of that cycle, excluding any write in the same cycle.
  - Later beats of the packet use the active set. Mid-packet writes affect only the next packet.
- Rewrite of output byte k:
  - If tkeep[k]=0: byte = 0x00.
  - Else, if some enabled rule's offset equals the lane offset: byte = (in & ~mask) | (data & mask), using the highest-index matching rule.
  - Else: byte passes through unchanged.
- tkeep, tlast and tuser pass through unchanged.
- Offsets beyond the packet length never match. The saturated beat index never re-matches on the final beat: matching is disabled once the counter is saturated.
- stat_rewrite_count:
  - Increments per accepted beat by the number of lanes rewritten; a mask of 0x00 still counts.
  - Saturates at 0xFFFFFFFF.

Test Plan:
- Reset and idle: hold rst_n=0 for 4 cycles with s_axis_tvalid=1 -> m_axis_tvalid=0 and stat_rewrite_count=0 throughout; s_axis_tready=1.
- Single rule, beat 0: rule0 = {en=1, off=5, data=0xAB, mask=0xFF}; send 1 beat, byte5=0x12, full keep -> output byte5=0xAB, all other bytes unchanged, latency 1 cycle, count=1.
- Cross-beat with mask: rule1 = {off=70, data=0xF0, mask=0xF0}; send a 3-beat packet with beat1 byte6=0x3C -> output 0xFC in beat1 lane6 only; beats 0 and 2 unchanged.
- Overlap and tkeep:
  - rule0 and rule3 both at off=2, rule3 data=0x55 -> 0x55 (highest index wins).
  - Last beat with tkeep=0x000F and a rule at off=130 (lane 2) -> rewritten.
  - Any lane >=4 -> 0x00.
- Mid-packet config: write rule0 off=64 during beat0 of a 2-beat packet -> that packet is not rewritten; the next identical packet has byte64 rewritten.
- Backpressure: m_axis_tready toggles 1010 over a 4-beat packet -> no beat is lost or duplicated, the held output is stable, and s_axis_tready=0 exactly when output is valid and not ready.
